// File: rtl/s_memory_port_sequencer.sv
// s_memory_port_sequencer
//
// Purpose: gives a single-port shared RAM (the RC4 S-memory) to NUM_TASKS task
// engines one at a time, in the order 0..NUM_TASKS-1. Each engine gets a
// one-cycle start pulse. Ownership moves on when the current engine raises
// its done flag. One turnaround cycle follows each hand-over, and no write is
// issued during that cycle. The memory-side outputs are registered.
//
// Ports:
//   clk, reset        system clock; synchronous active-high reset
//   start             level request to run the whole sequence (taken in IDLE/DONE)
//   task_address      packed per-task addresses, task k at [k*ADDR_W +: ADDR_W]
//   task_data         packed per-task write data, same packing
//   task_wren         per-task write enable
//   task_done         per-task done flag (level)
//   task_start        one-cycle start pulse to the owning task
//   s_address/s_data/s_wren  registered memory port
//   owner             index of the current port owner
//   busy              high in START, RUN, GAP
//   all_done          high in DONE
//   port_err          sticky protocol error
//
// Build option: define S_MEM_PORT_ERR_EN to enable the port_err checker.
// Without it, port_err is tied low.
//
// state | meaning
// IDLE  | waiting for start, no owner active
// START | pulse task_start[owner]; done is ignored (may be stale)
// RUN   | owner drives the port, waiting for its done
// GAP   | write-blocked turnaround, then advance owner or finish
// DONE  | all tasks finished, owner parked on last task

module s_memory_port_sequencer #(
  parameter int NUM_TASKS = 3,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  localparam int OWNER_W  = $clog2(NUM_TASKS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_TASKS*ADDR_W-1:0] task_address,
  input  logic [NUM_TASKS*DATA_W-1:0] task_data,
  input  logic [NUM_TASKS-1:0]        task_wren,
  input  logic [NUM_TASKS-1:0]        task_done,
  output logic [NUM_TASKS-1:0]        task_start,
  output logic [ADDR_W-1:0]           s_address,
  output logic [DATA_W-1:0]           s_data,
  output logic                        s_wren,
  output logic [OWNER_W-1:0]          owner,
  output logic                        busy,
  output logic                        all_done,
  output logic                        port_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [OWNER_W-1:0] LAST_OWNER = OWNER_W'(NUM_TASKS - 1);

  state_e               state_q, state_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [ADDR_W-1:0]    s_address_q;
  logic [DATA_W-1:0]    s_data_q;
  logic                 s_wren_q;

  logic [ADDR_W-1:0]    sel_address;
  logic [DATA_W-1:0]    sel_data;
  logic                 sel_wren;
  logic                 sel_done;
  logic [NUM_TASKS-1:0] owner_oh;

  // Select the owner's lane. A compare loop avoids an out-of-range part select
  // when NUM_TASKS is not a power of two.
  always_comb begin
    sel_address = '0;
    sel_data    = '0;
    sel_wren    = 1'b0;
    sel_done    = 1'b0;
    owner_oh    = '0;
    for (int k = 0; k < NUM_TASKS; k++) begin
      if (owner_q == OWNER_W'(k)) begin
        sel_address = task_address[k*ADDR_W +: ADDR_W];
        sel_data    = task_data[k*DATA_W +: DATA_W];
        sel_wren    = task_wren[k];
        sel_done    = task_done[k];
        owner_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    task_start = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_START;
          owner_d = '0;
        end
      end
      ST_START: begin
        task_start = owner_oh;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (sel_done) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (owner_q == LAST_OWNER) begin
          state_d = ST_DONE;
        end else begin
          owner_d = owner_q + OWNER_W'(1);
          state_d = ST_START;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_START;
          owner_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      s_address_q <= '0;
      s_data_q    <= '0;
      s_wren_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      s_address_q <= sel_address;
      s_data_q    <= sel_data;
      // Only RUN may write. The owner's write in its done cycle still lands.
      s_wren_q    <= (state_q == ST_RUN) & sel_wren;
    end
  end

  assign s_address = s_address_q;
  assign s_data    = s_data_q;
  assign s_wren    = s_wren_q;
  assign owner     = owner_q;
  assign busy      = (state_q == ST_START) || (state_q == ST_RUN) || (state_q == ST_GAP);
  assign all_done  = (state_q == ST_DONE);

`ifdef S_MEM_PORT_ERR_EN
  logic err_q;
  logic nonowner_wr;
  logic parked_wr;

  assign nonowner_wr = |(task_wren & ~owner_oh);
  assign parked_wr   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) & (|task_wren);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (nonowner_wr || parked_wr) begin
      err_q <= 1'b1;
    end
  end

  assign port_err = err_q;
`else
  assign port_err = 1'b0;
`endif

endmodule

// File: tb/tb_s_memory_port_sequencer.sv
module tb_s_memory_port_sequencer;

  localparam int NT = 3;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int OW = 2;

`ifdef S_MEM_PORT_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [NT*AW-1:0]  task_address;
  logic [NT*DW-1:0]  task_data;
  logic [NT-1:0]     task_wren;
  logic [NT-1:0]     task_done;
  logic [NT-1:0]     task_start;
  logic [AW-1:0]     s_address;
  logic [DW-1:0]     s_data;
  logic              s_wren;
  logic [OW-1:0]     owner;
  logic              busy;
  logic              all_done;
  logic              port_err;

  int checks = 0;
  int errors = 0;

  // Expected start pulses {owner, task_start}, memory writes {addr, data},
  // and sequence completions (expected owner when all_done rises).
  logic [4:0]  start_q[$];
  logic [15:0] wr_q[$];
  logic [1:0]  done_q[$];

  always #5 clk = ~clk;

  s_memory_port_sequencer #(.NUM_TASKS(NT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .task_address(task_address), .task_data(task_data),
    .task_wren(task_wren), .task_done(task_done),
    .task_start(task_start), .s_address(s_address), .s_data(s_data),
    .s_wren(s_wren), .owner(owner), .busy(busy), .all_done(all_done),
    .port_err(port_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_task_start"}, 32'(task_start), 32'd0);
    chk({tag, "_s_address"},  32'(s_address),  32'd0);
    chk({tag, "_s_data"},     32'(s_data),     32'd0);
    chk({tag, "_s_wren"},     32'(s_wren),     32'd0);
    chk({tag, "_owner"},      32'(owner),      32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_all_done"},   32'(all_done),   32'd0);
    chk({tag, "_port_err"},   32'(port_err),   32'd0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  logic       prev_done = 1'b0;
  logic [4:0]  exp_s;
  logic [15:0] exp_w;
  logic [1:0]  exp_o;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (task_start != '0) begin
          if (start_q.size() == 0) begin
            chk("unexpected_task_start", 32'(task_start), 32'd0);
          end else begin
            exp_s = start_q.pop_front();
            chk("task_start", 32'(task_start), 32'(exp_s[2:0]));
            chk("start_owner", 32'(owner), 32'(exp_s[4:3]));
            chk("start_busy", 32'(busy), 32'd1);
          end
        end
        if (s_wren) begin
          if (wr_q.size() == 0) begin
            chk("unexpected_s_wren", {16'd0, s_address, s_data}, 32'd0);
          end else begin
            exp_w = wr_q.pop_front();
            chk("s_address", 32'(s_address), 32'(exp_w[15:8]));
            chk("s_data", 32'(s_data), 32'(exp_w[7:0]));
          end
        end
        if (all_done && !prev_done) begin
          if (done_q.size() == 0) begin
            chk("unexpected_all_done", 32'(all_done), 32'd0);
          end else begin
            exp_o = done_q.pop_front();
            chk("done_owner", 32'(owner), 32'(exp_o));
            chk("done_busy", 32'(busy), 32'd0);
          end
        end
      end
      prev_done = all_done;
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0;
    task_address = '0; task_data = '0; task_wren = '0; task_done = '0;
    step(); step();
    chk_idle_outputs("reset");
    step();
    reset = 1'b0;
    step();

    // Basic sequence, owner 0
    start = 1'b1;
    start_q.push_back({2'd0, 3'b001});
    step();
    start = 1'b0;              // now in START
    step();                    // RUN owner 0
    task_wren[2] = 1'b1;       // non-owner write: no memory effect
    task_address[2*AW +: AW] = 8'h77;
    step();
    task_wren[2] = 1'b0;
    repeat (8) step();
    // Turnaround: write in the same cycle as done is committed
    task_done[0] = 1'b1;
    task_wren[0] = 1'b1;
    task_address[0 +: AW] = 8'hFF;
    task_data[0 +: DW] = 8'h11;
    wr_q.push_back({8'hFF, 8'h11});
    start_q.push_back({2'd1, 3'b010});
    step();
    task_done[0] = 1'b0;       // GAP
    task_wren[0] = 1'b0;
    step();                    // START owner 1
    step();                    // RUN owner 1
    task_done[2] = 1'b1;       // stale done held ahead of owner 2
    @(negedge clk);
    chk("port_err_after_nonowner", 32'(port_err), 32'(ERR_EXP));
    chk("owner_run1", 32'(owner), 32'd1);
    step();
    // Datapath: owner 1 write, non-owner 0 ignored
    task_address[1*AW +: AW] = 8'h3C;
    task_data[1*DW +: DW] = 8'hA5;
    task_wren[1] = 1'b1;
    task_wren[0] = 1'b1;
    task_address[0 +: AW] = 8'hFF;
    wr_q.push_back({8'h3C, 8'hA5});
    step();
    task_wren = '0;
    repeat (3) step();
    task_done[1] = 1'b1;
    start_q.push_back({2'd2, 3'b100});
    done_q.push_back(2'd2);
    step();
    task_done[1] = 1'b0;
    for (int i = 0; i < 20 && !all_done; i++) @(negedge clk);
    chk("all_done_reached", 32'(all_done), 32'd1);
    @(negedge clk);
    chk("done_owner_hold", 32'(owner), 32'd2);
    chk("port_err_sticky_done", 32'(port_err), 32'(ERR_EXP));

    // Restart without reset, then reset while owner 1 in RUN
    step();
    start = 1'b1;
    start_q.push_back({2'd0, 3'b001});
    step();
    start = 1'b0;              // START owner 0
    step();                    // RUN owner 0
    task_done[0] = 1'b1;
    start_q.push_back({2'd1, 3'b010});
    step();
    task_done[0] = 1'b0;       // GAP
    step();                    // START owner 1
    step();                    // RUN owner 1
    @(negedge clk);
    chk("restart_owner_run1", 32'(owner), 32'd1);
    chk("restart_busy", 32'(busy), 32'd1);
    step();
    reset = 1'b1;
    step();
    chk_idle_outputs("midreset");
    reset = 1'b0;
    task_done = '0;
    step();
    start = 1'b1;
    start_q.push_back({2'd0, 3'b001});
    step();
    start = 1'b0;
    step(); step();
    @(negedge clk);
    chk("start_q_drained", 32'(start_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
